// File: rtl/dlfloat_mac_host.sv
// Host-side driver for a DLfloat16 MAC pin interface: queues operand pairs onto a
// two-phase 16-bit bus and reassembles the byte-serial result stream into words.
module dlfloat_mac_host #(
  parameter int DEPTH    = 4,
  parameter int RX_PHASE = 1,
  parameter int RES_LAT  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic [15:0] bus_out,
  input  logic [7:0]  res_byte,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic [15:0] issued_cnt,
  output logic        busy
);

  localparam int   AW    = $clog2(DEPTH);
  localparam logic RX_PH = (RX_PHASE != 0);

  // Handshake: a pair is taken on any edge where op_valid && op_ready; op_ready
  // depends only on registered FIFO occupancy.
  logic [31:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               ph_q, ph_d;
  logic [15:0]        slot_a_q, slot_a_d, slot_b_q, slot_b_d;
  logic               slot_vld_q, slot_vld_d;
  logic [15:0]        issued_q, issued_d;
  logic [7:0]         msb_hold_q, msb_hold_d;
  logic [15:0]        res_data_q, res_data_d;
  logic               res_valid_q, res_valid_d;
  logic [RES_LAT-1:0] dl_q, dl_d;
  logic [2:0]         want_q, want_d;

  logic push, pop, emerge, lsb_edge, want_dec;

  assign op_ready = (cnt_q != (AW+1)'(DEPTH));
  assign push     = op_valid && op_ready;
  assign pop      = ph_q && (cnt_q != '0);
  assign emerge   = dl_q[RES_LAT-1];
  assign lsb_edge = (ph_q != RX_PH);
  assign want_dec = lsb_edge && (want_q != 3'd0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ph_d        = ~ph_q;
    slot_a_d    = slot_a_q;
    slot_b_d    = slot_b_q;
    slot_vld_d  = slot_vld_q;
    issued_d    = issued_q + 16'(pop);
    msb_hold_d  = msb_hold_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    want_d      = want_q;

    // New slot is loaded only at the end of the B cycle, so both bus words come from flops.
    if (ph_q) begin
      if (pop) begin
        slot_a_d   = mem_q[rd_ptr_q][31:16];
        slot_b_d   = mem_q[rd_ptr_q][15:0];
        slot_vld_d = 1'b1;
      end else begin
        slot_a_d   = 16'h0000;
        slot_b_d   = 16'h0000;
        slot_vld_d = 1'b0;
      end
    end

    dl_d[0] = slot_vld_q && ph_q;
    for (int i = 1; i < RES_LAT; i++) dl_d[i] = dl_q[i-1];

    if (lsb_edge) begin
      res_data_d  = {msb_hold_q, res_byte};
      res_valid_d = (want_q != 3'd0);
    end else begin
      msb_hold_d = res_byte;
    end

    // Simultaneous arrival and consumption leave the outstanding count unchanged.
    case ({emerge, want_dec})
      2'b10:   want_d = (want_q == 3'd7) ? want_q : want_q + 3'd1;
      2'b01:   want_d = want_q - 3'd1;
      default: want_d = want_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {op_a, op_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ph_q        <= 1'b0;
      slot_a_q    <= 16'h0000;
      slot_b_q    <= 16'h0000;
      slot_vld_q  <= 1'b0;
      issued_q    <= 16'h0000;
      msb_hold_q  <= 8'h00;
      res_data_q  <= 16'h0000;
      res_valid_q <= 1'b0;
      dl_q        <= '0;
      want_q      <= 3'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      slot_a_q    <= slot_a_d;
      slot_b_q    <= slot_b_d;
      slot_vld_q  <= slot_vld_d;
      issued_q    <= issued_d;
      msb_hold_q  <= msb_hold_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      dl_q        <= dl_d;
      want_q      <= want_d;
    end
  end

  assign bus_out    = ph_q ? slot_b_q : slot_a_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign issued_cnt = issued_q;
  assign busy       = (cnt_q != '0) || slot_vld_q || (dl_q != '0) || (want_q != 3'd0);

endmodule

// File: tb/tb_dlfloat_mac_host.sv
// Directed bench for dlfloat_mac_host: per-cycle vector tables, a bus/result
// scoreboard and a small MAC byte-stream model that replays the expected results.
module tb_dlfloat_mac_host;

  localparam int RX_PHASE = 1;
  localparam int RES_LAT  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] op_a = 16'h0, op_b = 16'h0;
  logic [15:0] bus_out;
  logic [7:0]  res_byte = 8'h00;
  logic        res_valid;
  logic [15:0] res_data;
  logic [15:0] issued_cnt;
  logic        busy;

  dlfloat_mac_host #(.DEPTH(4), .RX_PHASE(RX_PHASE), .RES_LAT(RES_LAT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .bus_out(bus_out), .res_byte(res_byte),
    .res_valid(res_valid), .res_data(res_data), .issued_cnt(issued_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
  } op_t;

  typedef struct {
    logic [15:0] bus;
    logic        ready;
    logic        busy;
  } vec_t;

  // Scoreboard: {a, b, result} per accepted pair; results expected on res_valid.
  logic [47:0] exp_q[$];
  logic [15:0] res_exp_q[$];
  int          mac_due_q[$];
  logic [15:0] mac_val_q[$];

  logic [15:0] acc, a_seen, cur_r;
  bit          pend, prev_valid;
  int          cyc, n_push, n_pop, n_pulses, last_pulse;
  int          n_pass = 0, n_total = 0;

  op_t  ops4[4];
  vec_t vec4[12];
  op_t  rx_ops[2];

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic note_fail(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_total++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // MAC model: a result becomes visible RES_LAT cycles after its B slot,
  // MSB byte in RX_PHASE cycles, LSB byte in the other phase.
  task automatic drive_rx();
    while (mac_due_q.size() > 0 && mac_due_q[0] <= cyc) begin
      acc = mac_val_q.pop_front();
      void'(mac_due_q.pop_front());
    end
    res_byte = ((cyc % 2) == RX_PHASE) ? acc[15:8] : acc[7:0];
  endtask

  task automatic monitor();
    logic [47:0] e;
    if (res_valid) begin
      n_pulses++;
      last_pulse = cyc;
      chk("res_valid_gap", prev_valid, 1'b0);
      if (res_exp_q.size() == 0) note_fail("untracked_res_valid", res_data, 0);
      else chk("res_data", res_data, res_exp_q.pop_front());
    end
    prev_valid = res_valid;
    if ((cyc % 2) == 0) begin
      pend   = (bus_out != 16'h0);
      a_seen = bus_out;
    end else if (pend) begin
      pend = 1'b0;
      if (exp_q.size() == 0) begin
        note_fail("bus_pair_unexpected", {a_seen, bus_out}, 0);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        chk("bus_pair", {a_seen, bus_out}, e[47:16]);
        res_exp_q.push_back(e[15:0]);
        mac_due_q.push_back(cyc + RES_LAT);
        mac_val_q.push_back(e[15:0]);
      end
    end else if (bus_out != 16'h0) begin
      note_fail("bus_b_without_a", bus_out, 0);
    end
  endtask

  task automatic step();
    if (op_valid && op_ready) begin
      exp_q.push_back({op_a, op_b, cur_r});
      n_push++;
    end
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    drive_rx();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_valid = 1'b0;
    exp_q.delete(); res_exp_q.delete(); mac_due_q.delete(); mac_val_q.delete();
    acc = 16'h0; pend = 1'b0; prev_valid = 1'b0;
    n_push = 0; n_pop = 0; n_pulses = 0; last_pulse = -1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    drive_rx();
  endtask

  task automatic set_op(input logic v, input op_t o);
    op_valid = v;
    op_a = o.a;
    op_b = o.b;
    cur_r = o.r;
  endtask

  initial begin
    ops4[0] = '{16'h3E00, 16'h3E00, 16'h3E00};  // 1*1 -> 1.0
    ops4[1] = '{16'h3E00, 16'h4000, 16'h4100};  // +1*2 -> 3.0
    ops4[2] = '{16'h4000, 16'h4000, 16'h4380};  // +2*2 -> 7.0
    ops4[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};  // NaN pattern passes bit-exact
    vec4[0]  = '{16'h0000, 1'b1, 1'b0};
    vec4[1]  = '{16'h0000, 1'b1, 1'b1};
    vec4[2]  = '{16'h3E00, 1'b1, 1'b1};
    vec4[3]  = '{16'h3E00, 1'b1, 1'b1};
    vec4[4]  = '{16'h3E00, 1'b1, 1'b1};
    vec4[5]  = '{16'h4000, 1'b1, 1'b1};
    vec4[6]  = '{16'h4000, 1'b1, 1'b1};
    vec4[7]  = '{16'h4000, 1'b1, 1'b1};
    vec4[8]  = '{16'hFFFF, 1'b1, 1'b1};
    vec4[9]  = '{16'hFFFF, 1'b1, 1'b1};
    vec4[10] = '{16'h0000, 1'b1, 1'b1};
    vec4[11] = '{16'h0000, 1'b1, 1'b1};
    rx_ops[0] = '{16'h3E00, 16'h3E00, 16'h4180};
    rx_ops[1] = '{16'h3E00, 16'h3E00, 16'h8041};

    // Idle after reset: nothing on the bus, no results.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chk("idle_bus", bus_out, 16'h0);
      chk("idle_res_valid", res_valid, 1'b0);
      chk("idle_issued", issued_cnt, 16'h0);
      chk("idle_ready", op_ready, 1'b1);
      step();
    end
    chk("idle_res_data", res_data, 16'h0);
    chk("idle_busy", busy, 1'b0);

    // Single pair 1.0 x 2.0, pushed at cycle 0.
    do_reset();
    set_op(1'b1, '{16'h3E00, 16'h4000, 16'h4000});
    step();
    op_valid = 1'b0;
    while (cyc < 30) begin
      if (cyc == 2) chk("single_bus_a", bus_out, 16'h3E00);
      if (cyc == 3) begin
        chk("single_bus_b", bus_out, 16'h4000);
        chk("single_issued", issued_cnt, 16'd1);
      end
      step();
    end
    chk("single_pulses", n_pulses, 1);
    chk("single_pulse_cycle", last_pulse, 11);
    chk("single_res_data", res_data, 16'h4000);
    chk("single_busy_end", busy, 1'b0);

    // Four pairs back-to-back, per-cycle bus/ready/busy table.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      chk("quad_bus", bus_out, vec4[i].bus);
      chk("quad_ready", op_ready, vec4[i].ready);
      chk("quad_busy", busy, vec4[i].busy);
      if (i < 4) set_op(1'b1, ops4[i]);
      else op_valid = 1'b0;
      step();
    end
    while (cyc < 30) step();
    chk("quad_pulses", n_pulses, 4);
    chk("quad_issued", issued_cnt, 16'd4);
    chk("quad_res_left", res_exp_q.size(), 0);
    chk("quad_busy_end", busy, 1'b0);

    // Byte order: RX_PHASE byte is the MSB of the word.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_op(1'b1, rx_ops[i]);
      step();
    end
    op_valid = 1'b0;
    while (cyc < 30) begin
      if (cyc == 11) chk("rx_word0", res_data, 16'h4180);
      if (cyc == 13) chk("rx_word1", res_data, 16'h8041);
      step();
    end
    chk("rx_pulses", n_pulses, 2);

    // Continuous offer until the FIFO fills; the source holds the pair while not ready.
    do_reset();
    while (cyc < 45) begin
      if (cyc == 7) chk("fill_ready_c7", op_ready, 1'b0);
      if (cyc == 8) chk("fill_ready_c8", op_ready, 1'b1);
      if (cyc == 9) chk("fill_ready_c9", op_ready, 1'b0);
      if (cyc == 9) chk("fill_busy", busy, 1'b1);
      set_op(n_push < 10, '{16'h1000 + 16'(n_push), 16'h2000 + 16'(n_push), 16'h3000 + 16'(n_push)});
      step();
    end
    chk("fill_pushed", n_push, 10);
    chk("fill_popped", n_pop, 10);
    chk("fill_issued", issued_cnt, 16'd10);
    chk("fill_pulses", n_pulses, 10);
    chk("fill_busy_end", busy, 1'b0);

    // Reset between A and B slots of the second of three ops.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, '{16'h1111 * 16'(i + 1), 16'h0101 * 16'(i + 1), 16'h5000 + 16'(i)});
      step();
    end
    op_valid = 1'b0;
    step();
    chk("midrst_bus_a", bus_out, 16'h2222);
    rst = 1'b1;
    #1;
    chk("midrst_bus_zero", bus_out, 16'h0);
    chk("midrst_ready", op_ready, 1'b1);
    chk("midrst_issued", issued_cnt, 16'h0);
    chk("midrst_busy", busy, 1'b0);
    do_reset();
    while (cyc < 20) step();
    chk("midrst_no_pulse", n_pulses, 0);
    chk("midrst_issued_idle", issued_cnt, 16'h0);
    set_op(1'b1, '{16'h3E00, 16'h4000, 16'h4000});
    step();
    op_valid = 1'b0;
    while (cyc < 40) begin
      if (cyc == 22) chk("midrst_new_a", bus_out, 16'h3E00);
      if (cyc == 23) chk("midrst_new_b", bus_out, 16'h4000);
      step();
    end
    chk("midrst_new_pulses", n_pulses, 1);
    chk("midrst_new_issued", issued_cnt, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
